// File: rtl/updown_counter_with_history_pkg.sv
// Shared constants and helpers for the up/down counter with history FIFO.
package counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/updown_counter_with_history_if.sv
// Button/switch inputs and counter/history outputs of the counter block.
interface updown_counter_with_history_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  import counter_pkg::*;

  localparam int CNT_W = clog2(DEPTH + 1);

  logic             upButton;
  logic             downButton;
  logic             loadButton;
  logic             popButton;
  logic [WIDTH-1:0] switches;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] fifoHead;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             overflow;

  // Board side: drives the raw buttons and switches, watches the results.
  modport master (
    output upButton, downButton, loadButton, popButton, switches,
    input  counter, fifoHead, fifoCount, fifoEmpty, fifoFull, overflow
  );

  // Counter side.
  modport slave (
    input  upButton, downButton, loadButton, popButton, switches,
    output counter, fifoHead, fifoCount, fifoEmpty, fifoFull, overflow
  );
endinterface

// File: rtl/updown_counter_with_history_debouncer.sv
// Two-flop synchroniser plus tick-sampled debouncer emitting one pulse per press.
module button_debouncer import counter_pkg::*; #(
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic systemClock,
  input  logic resetButtonN,
  input  logic i_tick,
  input  logic i_button,
  output logic o_pulse
);
  localparam int SC_W = clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(DEBOUNCE_SAMPLES - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSING  = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_RELEASING = 2'd3;

  logic            r_sync1, r_sync2;
  logic [1:0]      r_state, w_state_next;
  logic [SC_W-1:0] r_samples, w_samples_next;
  // Cleared by reset: IDLE will not accept a press until the button has been
  // seen released for a full qualification, so a button held through reset
  // never produces an action.
  logic            r_armed, w_armed_next;
  logic            r_pulse, w_pulse_next;

  // Bring the raw button into the clock domain.
  always_ff @(posedge systemClock or negedge resetButtonN) begin
    if (!resetButtonN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic; only advances on the sample tick.
  always_comb begin
    w_state_next   = r_state;
    w_samples_next = r_samples;
    w_armed_next   = r_armed;
    w_pulse_next   = 1'b0;
    if (i_tick) begin
      case (r_state)
        ST_PRESSING: begin
          if (!r_sync2) begin
            w_state_next   = ST_IDLE;
            w_samples_next = '0;
          end else if (r_samples == LAST_SAMPLE) begin
            w_state_next   = ST_HELD;
            w_samples_next = '0;
            w_pulse_next   = 1'b1;
          end else begin
            w_samples_next = r_samples + SC_W'(1);
          end
        end
        ST_HELD: begin
          if (!r_sync2) begin
            w_state_next   = ST_RELEASING;
            w_samples_next = SC_W'(1);
          end
        end
        ST_RELEASING: begin
          if (r_sync2) begin
            w_state_next   = ST_HELD;
            w_samples_next = '0;
          end else if (r_samples == LAST_SAMPLE) begin
            w_state_next   = ST_IDLE;
            w_samples_next = '0;
          end else begin
            w_samples_next = r_samples + SC_W'(1);
          end
        end
        default: begin
          if (!r_armed) begin
            if (r_sync2) begin
              w_samples_next = '0;
            end else if (r_samples == LAST_SAMPLE) begin
              w_armed_next   = 1'b1;
              w_samples_next = '0;
            end else begin
              w_samples_next = r_samples + SC_W'(1);
            end
          end else if (r_sync2) begin
            w_state_next   = ST_PRESSING;
            w_samples_next = SC_W'(1);
          end
        end
      endcase
    end
  end

  // State, sample count and registered action pulse.
  always_ff @(posedge systemClock or negedge resetButtonN) begin
    if (!resetButtonN) begin
      r_state   <= ST_IDLE;
      r_samples <= '0;
      r_armed   <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_samples <= w_samples_next;
      r_armed   <= w_armed_next;
      r_pulse   <= w_pulse_next;
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/updown_counter_with_history.sv
// Debounced up/down/load counter that logs every change into a history FIFO.
module updown_counter_with_history import counter_pkg::*; #(
  parameter int WIDTH             = 4,
  parameter int CLOCK_SCALER_BITS = 16,
  parameter int DEBOUNCE_SAMPLES  = 3,
  parameter int SATURATE          = MODE_WRAP,
  parameter int DEPTH             = 4
) (
  input logic systemClock,
  input logic resetButtonN,
  updown_counter_with_history_if.slave bus
);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int PTR_W = clog2(DEPTH);
  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  logic [CLOCK_SCALER_BITS-1:0] r_scaler;
  logic                         w_tick;
  logic [3:0]                   w_raw_buttons, w_actions;
  logic                         w_up, w_down, w_load, w_pop;

  logic [WIDTH-1:0] r_counter, w_value_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
  logic [CNT_W-1:0] r_fifo_count, w_fifo_count_next;
  logic [WIDTH-1:0] r_head, w_head_next;
  logic             r_overflow;
  logic             w_push, w_pop_ok, w_empty, w_full;

  // Free-running prescaler; the all-ones cycle is the one-cycle sample tick.
  always_ff @(posedge systemClock or negedge resetButtonN) begin
    if (!resetButtonN) r_scaler <= '0;
    else               r_scaler <= r_scaler + CLOCK_SCALER_BITS'(1);
  end
  assign w_tick = &r_scaler;

  assign w_raw_buttons = {bus.popButton, bus.loadButton, bus.downButton, bus.upButton};
  for (genvar gi = 0; gi < 4; gi++) begin : g_button
    button_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_debouncer (
      .systemClock  (systemClock),
      .resetButtonN (resetButtonN),
      .i_tick       (w_tick),
      .i_button     (w_raw_buttons[gi]),
      .o_pulse      (w_actions[gi])
    );
  end
  assign {w_pop, w_load, w_down, w_up} = w_actions;

  // Next count: load wins, up+down cancel, saturate mode ignores steps past the ends.
  always_comb begin
    w_value_next = r_counter;
    if (w_load) begin
      w_value_next = bus.switches;
    end else if (w_up && !w_down) begin
      if (!(SATURATE == MODE_SATURATE && r_counter == MAX_VALUE))
        w_value_next = r_counter + WIDTH'(1);
    end else if (w_down && !w_up) begin
      if (!(SATURATE == MODE_SATURATE && r_counter == '0))
        w_value_next = r_counter - WIDTH'(1);
    end
  end

  // Only a real change of value is a commit.
  assign w_push   = (w_value_next != r_counter);
  assign w_empty  = (r_fifo_count == '0);
  assign w_full   = (r_fifo_count == CNT_W'(DEPTH));
  assign w_pop_ok = w_pop && !w_empty;

  // FIFO bookkeeping: a push into a full FIFO without a pop drops the oldest entry.
  always_comb begin
    w_rd_next         = r_rd_ptr;
    w_fifo_count_next = r_fifo_count;
    if (w_pop_ok || (w_push && w_full))
      w_rd_next = r_rd_ptr + PTR_W'(1);
    if (w_push && !w_pop_ok && !w_full)
      w_fifo_count_next = r_fifo_count + CNT_W'(1);
    else if (w_pop_ok && !w_push)
      w_fifo_count_next = r_fifo_count - CNT_W'(1);
    // The entry written this cycle becomes the head when it lands on the new read slot.
    if (w_fifo_count_next == '0)
      w_head_next = '0;
    else if (w_push && (w_rd_next == r_wr_ptr))
      w_head_next = w_value_next;
    else
      w_head_next = r_mem[w_rd_next];
  end

  // History storage; contents are don't-care until written, so no reset.
  always_ff @(posedge systemClock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_value_next;
  end

  // Counter, pointers, count, registered head and sticky overflow.
  always_ff @(posedge systemClock or negedge resetButtonN) begin
    if (!resetButtonN) begin
      r_counter    <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fifo_count <= '0;
      r_head       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_counter    <= w_value_next;
      r_rd_ptr     <= w_rd_next;
      r_fifo_count <= w_fifo_count_next;
      r_head       <= w_head_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_push && w_full && !w_pop_ok) r_overflow <= 1'b1;
    end
  end

  assign bus.counter   = r_counter;
  assign bus.fifoHead  = r_head;
  assign bus.fifoCount = r_fifo_count;
  assign bus.fifoEmpty = w_empty;
  assign bus.fifoFull  = w_full;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_updown_counter_with_history.sv
// Bench: one wrap-mode and one saturate-mode counter driven by the same buttons.
module tb_updown_counter_with_history;
  localparam int W    = 6;
  localparam int CSB  = 2;
  localparam int DS   = 3;
  localparam int D    = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int CW   = counter_pkg::clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_b = 1'b0, down_b = 1'b0, load_b = 1'b0, pop_b = 1'b0;
  logic [W-1:0] sw = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter_with_history_if #(.WIDTH(W), .DEPTH(D)) bus_wrap ();
  updown_counter_with_history_if #(.WIDTH(W), .DEPTH(D)) bus_sat ();

  assign bus_wrap.upButton = up_b;   assign bus_sat.upButton = up_b;
  assign bus_wrap.downButton = down_b; assign bus_sat.downButton = down_b;
  assign bus_wrap.loadButton = load_b; assign bus_sat.loadButton = load_b;
  assign bus_wrap.popButton = pop_b;  assign bus_sat.popButton = pop_b;
  assign bus_wrap.switches = sw;      assign bus_sat.switches = sw;

  updown_counter_with_history #(.WIDTH(W), .CLOCK_SCALER_BITS(CSB), .DEBOUNCE_SAMPLES(DS),
    .SATURATE(0), .DEPTH(D)) dut_wrap (.systemClock(clk), .resetButtonN(rst_n), .bus(bus_wrap));
  updown_counter_with_history #(.WIDTH(W), .CLOCK_SCALER_BITS(CSB), .DEBOUNCE_SAMPLES(DS),
    .SATURATE(1), .DEPTH(D)) dut_sat (.systemClock(clk), .resetButtonN(rst_n), .bus(bus_sat));

  // Observed outputs, index 0 = wrap DUT, 1 = saturate DUT.
  logic [W-1:0]  o_cnt [2];
  logic [W-1:0]  o_head [2];
  logic [CW-1:0] o_fc [2];
  logic          o_emp [2], o_full [2], o_ovf [2];
  assign o_cnt[0] = bus_wrap.counter;   assign o_cnt[1] = bus_sat.counter;
  assign o_head[0] = bus_wrap.fifoHead; assign o_head[1] = bus_sat.fifoHead;
  assign o_fc[0] = bus_wrap.fifoCount;  assign o_fc[1] = bus_sat.fifoCount;
  assign o_emp[0] = bus_wrap.fifoEmpty; assign o_emp[1] = bus_sat.fifoEmpty;
  assign o_full[0] = bus_wrap.fifoFull; assign o_full[1] = bus_sat.fifoFull;
  assign o_ovf[0] = bus_wrap.overflow;  assign o_ovf[1] = bus_sat.overflow;

  // Reference model: count value plus history kept oldest-first in a plain array.
  int m_cnt [2];
  int m_fifo [2][D];
  int m_n [2];
  bit m_ovf [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_n[k] = 0; m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void drop_oldest(input int k);
    for (int i = 0; i < D - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
    m_n[k] = m_n[k] - 1;
  endfunction

  function automatic void model_apply(input bit l, input bit u, input bit d, input bit p, input int s);
    for (int k = 0; k < 2; k++) begin
      int nxt;
      nxt = m_cnt[k];
      if (l) nxt = s;
      else if (u && !d) nxt = (k == 1) ? ((m_cnt[k] == MAXV) ? MAXV : m_cnt[k] + 1) : (m_cnt[k] + 1) % (MAXV + 1);
      else if (d && !u) nxt = (k == 1) ? ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1) : (m_cnt[k] + MAXV) % (MAXV + 1);
      if (p && m_n[k] > 0) drop_oldest(k);
      if (nxt != m_cnt[k]) begin
        if (m_n[k] == D) begin
          drop_oldest(k);
          m_ovf[k] = 1'b1;
        end
        m_fifo[k][m_n[k]] = nxt;
        m_n[k] = m_n[k] + 1;
      end
      m_cnt[k] = nxt;
    end
  endfunction

  // Hold a button combination long enough to qualify, release, let it re-arm.
  task automatic act(input bit l, input bit u, input bit d, input bit p, input logic [W-1:0] s);
    @(negedge clk);
    sw = s; load_b = l; up_b = u; down_b = d; pop_b = p;
    repeat (40) @(negedge clk);
    load_b = 1'b0; up_b = 1'b0; down_b = 1'b0; pop_b = 1'b0;
    repeat (30) @(negedge clk);
    model_apply(l, u, d, p, int'(s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_cnt[k] !== '0) begin failures++; $display("FAIL reset_counter[%0d] got=%0d exp=0", k, o_cnt[k]); end
      checks++; if (o_head[k] !== '0) begin failures++; $display("FAIL reset_head[%0d] got=%0d exp=0", k, o_head[k]); end
      checks++; if (o_fc[k] !== '0) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, o_fc[k]); end
      checks++; if (o_emp[k] !== 1'b1) begin failures++; $display("FAIL reset_empty[%0d] got=%0b exp=1", k, o_emp[k]); end
      checks++; if (o_full[k] !== 1'b0) begin failures++; $display("FAIL reset_full[%0d] got=%0b exp=0", k, o_full[k]); end
      checks++; if (o_ovf[k] !== 1'b0) begin failures++; $display("FAIL reset_overflow[%0d] got=%0b exp=0", k, o_ovf[k]); end
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_short_press();
    @(negedge clk);
    up_b = 1'b1;
    repeat (5) @(negedge clk);
    up_b = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (o_cnt[0] !== 6'd0) begin failures++; $display("FAIL short_press_counter got=%0d exp=0", o_cnt[0]); end
    checks++; if (o_emp[0] !== 1'b1) begin failures++; $display("FAIL short_press_empty got=%0b exp=1", o_emp[0]); end
    act(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (o_cnt[0] !== 6'd1) begin failures++; $display("FAIL long_press_counter got=%0d exp=1", o_cnt[0]); end
    checks++; if (o_head[0] !== 6'd1) begin failures++; $display("FAIL long_press_head got=%0d exp=1", o_head[0]); end
    checks++; if (o_fc[0] !== CW'(1)) begin failures++; $display("FAIL long_press_count got=%0d exp=1", o_fc[0]); end
    $display("test_short_press counter=%0d", o_cnt[0]);
  endtask

  task automatic test_wrap_saturate();
    act(1'b1, 1'b0, 1'b0, 1'b0, 6'd63);
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_cnt[k] !== 6'd63) begin failures++; $display("FAIL load63_counter[%0d] got=%0d exp=63", k, o_cnt[k]); end
    end
    act(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (o_cnt[0] !== 6'd0) begin failures++; $display("FAIL wrap_counter got=%0d exp=0", o_cnt[0]); end
    checks++; if (o_fc[0] !== CW'(3)) begin failures++; $display("FAIL wrap_count got=%0d exp=3", o_fc[0]); end
    checks++; if (o_cnt[1] !== 6'd63) begin failures++; $display("FAIL sat_counter got=%0d exp=63", o_cnt[1]); end
    checks++; if (o_fc[1] !== CW'(2)) begin failures++; $display("FAIL sat_count got=%0d exp=2", o_fc[1]); end
    $display("test_wrap_saturate wrap=%0d sat=%0d", o_cnt[0], o_cnt[1]);
  endtask

  task automatic test_cancel_and_priority();
    act(1'b0, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_cnt[k] !== W'(m_cnt[k])) begin failures++; $display("FAIL cancel_counter[%0d] got=%0d exp=%0d", k, o_cnt[k], m_cnt[k]); end
      checks++; if (o_fc[k] !== CW'(m_n[k])) begin failures++; $display("FAIL cancel_count[%0d] got=%0d exp=%0d", k, o_fc[k], m_n[k]); end
    end
    act(1'b1, 1'b1, 1'b0, 1'b0, 6'd9);
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_cnt[k] !== 6'd9) begin failures++; $display("FAIL load_priority[%0d] got=%0d exp=9", k, o_cnt[k]); end
    end
    $display("test_cancel_and_priority counter=%0d", o_cnt[0]);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit l, u, d, p;
      logic [W-1:0] s;
      l = ($urandom_range(0, 3) == 0);
      u = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      p = ($urandom_range(0, 2) == 0);
      s = W'($urandom_range(0, MAXV));
      act(l, u, d, p, s);
      for (int k = 0; k < 2; k++) begin
        int eh;
        eh = (m_n[k] > 0) ? m_fifo[k][0] : 0;
        checks++; if (o_cnt[k] !== W'(m_cnt[k])) begin failures++; $display("FAIL rand_counter[%0d] got=%0d exp=%0d", k, o_cnt[k], m_cnt[k]); end
        checks++; if (o_head[k] !== W'(eh)) begin failures++; $display("FAIL rand_head[%0d] got=%0d exp=%0d", k, o_head[k], eh); end
        checks++; if (o_fc[k] !== CW'(m_n[k])) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", k, o_fc[k], m_n[k]); end
        checks++; if (o_emp[k] !== (m_n[k] == 0)) begin failures++; $display("FAIL rand_empty[%0d] got=%0b exp=%0b", k, o_emp[k], m_n[k] == 0); end
        checks++; if (o_full[k] !== (m_n[k] == D)) begin failures++; $display("FAIL rand_full[%0d] got=%0b exp=%0b", k, o_full[k], m_n[k] == D); end
        checks++; if (o_ovf[k] !== m_ovf[k]) begin failures++; $display("FAIL rand_overflow[%0d] got=%0b exp=%0b", k, o_ovf[k], m_ovf[k]); end
      end
      $display("rand %0d: l=%0b u=%0b d=%0b p=%0b sw=%0d -> counter=%0d/%0d count=%0d/%0d", n, l, u, d, p, s, o_cnt[0], o_cnt[1], o_fc[0], o_fc[1]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 1; v <= 6; v++) act(1'b1, 1'b0, 1'b0, 1'b0, W'(v));
    checks++; if (o_fc[0] !== CW'(4)) begin failures++; $display("FAIL ovf_count got=%0d exp=4", o_fc[0]); end
    checks++; if (o_head[0] !== 6'd3) begin failures++; $display("FAIL ovf_head got=%0d exp=3", o_head[0]); end
    checks++; if (o_full[0] !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0b exp=1", o_full[0]); end
    checks++; if (o_ovf[0] !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", o_ovf[0]); end
    for (int i = 0; i < 4; i++) begin
      act(1'b0, 1'b0, 1'b0, 1'b1, '0);
      checks++; if (o_head[0] !== W'(m_n[0] > 0 ? m_fifo[0][0] : 0)) begin failures++; $display("FAIL pop_head got=%0d exp=%0d", o_head[0], m_n[0] > 0 ? m_fifo[0][0] : 0); end
    end
    checks++; if (o_emp[0] !== 1'b1) begin failures++; $display("FAIL drained_empty got=%0b exp=1", o_emp[0]); end
    act(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++; if (o_fc[0] !== CW'(0)) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", o_fc[0]); end
    checks++; if (o_head[0] !== 6'd0) begin failures++; $display("FAIL empty_pop_head got=%0d exp=0", o_head[0]); end
    checks++; if (o_ovf[0] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", o_ovf[0]); end
    $display("test_overflow count=%0d overflow=%0b", o_fc[0], o_ovf[0]);
  endtask

  task automatic test_pop_push();
    do_reset();
    act(1'b1, 1'b0, 1'b0, 1'b0, 6'd5);
    act(1'b1, 1'b0, 1'b0, 1'b0, 6'd6);
    act(1'b0, 1'b1, 1'b0, 1'b1, '0);
    checks++; if (o_cnt[0] !== 6'd7) begin failures++; $display("FAIL popush_counter got=%0d exp=7", o_cnt[0]); end
    checks++; if (o_head[0] !== 6'd6) begin failures++; $display("FAIL popush_head got=%0d exp=6", o_head[0]); end
    checks++; if (o_fc[0] !== CW'(2)) begin failures++; $display("FAIL popush_count got=%0d exp=2", o_fc[0]); end
    act(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++; if (o_head[0] !== 6'd7) begin failures++; $display("FAIL popush_tail got=%0d exp=7", o_head[0]); end
    $display("test_pop_push head=%0d count=%0d", o_head[0], o_fc[0]);
  endtask

  task automatic test_reset_midpress();
    do_reset();
    act(1'b1, 1'b0, 1'b0, 1'b0, 6'd12);
    checks++; if (o_cnt[0] !== 6'd12) begin failures++; $display("FAIL midpress_load got=%0d exp=12", o_cnt[0]); end
    @(negedge clk);
    up_b = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (o_cnt[0] !== 6'd0) begin failures++; $display("FAIL midpress_rst_counter got=%0d exp=0", o_cnt[0]); end
    checks++; if (o_emp[0] !== 1'b1) begin failures++; $display("FAIL midpress_rst_empty got=%0b exp=1", o_emp[0]); end
    checks++; if (o_fc[0] !== CW'(0)) begin failures++; $display("FAIL midpress_rst_count got=%0d exp=0", o_fc[0]); end
    checks++; if (o_head[0] !== 6'd0) begin failures++; $display("FAIL midpress_rst_head got=%0d exp=0", o_head[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (o_cnt[0] !== 6'd0) begin failures++; $display("FAIL held_through_reset got=%0d exp=0", o_cnt[0]); end
    up_b = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (o_emp[0] !== 1'b1) begin failures++; $display("FAIL after_release_empty got=%0b exp=1", o_emp[0]); end
    act(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (o_cnt[0] !== 6'd1) begin failures++; $display("FAIL repress_counter got=%0d exp=1", o_cnt[0]); end
    $display("test_reset_midpress counter=%0d", o_cnt[0]);
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_wrap_saturate();
    test_cancel_and_priority();
    test_random();
    test_overflow();
    test_pop_push();
    test_reset_midpress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
